// File: rtl/multiplier_seq.sv
// Iterative shift-add multiply-accumulate: product = multiplicand * multiplier + addend.
// One radix-2 step per clock, fixed latency of N steps, one operation in flight.
// Used as the inverse of the divider: (quotient, divisor, remainder) -> dividend.
module multiplier_seq #(
    parameter int M = 26,
    parameter int N = 14
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [M-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    input  logic [N-1:0]   addend,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [M+N-1:0] product
);

    localparam int W     = M + N;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [W-1:0]     mcand_q, mcand_d;
    logic [N-1:0]     mplr_q, mplr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     product_q, product_d;
    logic [W-1:0]     step_acc;

    // Accumulator value after the current step; the (2^N-1)*2^M bound means no carry-out is needed.
    always_comb begin
        step_acc = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
    end

    // Next-state and datapath updates; every register holds unless its state moves it.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = {{M{1'b0}}, addend};
                    mcand_d = {{N{1'b0}}, multiplicand};
                    mplr_d  = multiplier;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d   = step_acc;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                // Fixed latency: no early exit even when mplr has run out of ones.
                if (cnt_q == CNT_W'(N - 1)) begin
                    product_d = step_acc;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplr_q    <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = product_q;

endmodule

// File: tb/tb_multiplier_seq.sv
// Directed bench for multiplier_seq plus a divider round-trip sweep.
module tb_multiplier_seq;

    localparam int M = 26;
    localparam int N = 14;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [M-1:0]  multiplicand;
    logic [N-1:0]  multiplier;
    logic [N-1:0]  addend;
    logic          out_valid;
    logic          out_ready;
    logic [M+N-1:0] product;

    int checks;
    int errors;

    multiplier_seq #(.M(M), .N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .addend       (addend),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands, get them accepted, then wait (bounded) for out_valid.
    task automatic start_and_wait(input logic [M-1:0] mc, input logic [N-1:0] mp,
                                  input logic [N-1:0] ad, output int lat);
        multiplicand = mc;
        multiplier   = mp;
        addend       = ad;
        in_valid     = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            check("busy_in_ready", 64'(in_ready), 64'd0);
            step();
            lat++;
        end
    endtask

    // Full operation with out_ready held high: latency, result, single-cycle DONE.
    task automatic run_op(input string tag, input logic [M-1:0] mc, input logic [N-1:0] mp,
                          input logic [N-1:0] ad, input logic [M+N-1:0] exp);
        int lat;
        out_ready = 1'b1;
        start_and_wait(mc, mp, ad, lat);
        check({tag, "_latency"}, 64'(lat), 64'd14);
        check({tag, "_product"}, 64'(product), 64'(exp));
        check({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
        step();
        check({tag, "_out_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
        check({tag, "_product_held"}, 64'(product), 64'(exp));
    endtask

    logic [M-1:0] dvd [1000];
    logic [N-1:0] dvs [1000];

    initial begin
        int lat;
        int wait_cnt;
        logic [M+N-1:0] held;
        logic [M-1:0] q;
        logic [N-1:0] r;

        checks       = 0;
        errors       = 0;
        rst          = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        addend       = '0;
        #2 rst = 1'b1;
        step();
        step();
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_product", 64'(product), 64'd0);
        rst = 1'b0;
        step();

        // Basic, max operands, zero multiplier.
        run_op("basic", 26'd100, 14'd7, 14'd3, 40'd703);
        run_op("max", 26'h3FFFFFF, 14'h3FFF, 14'h3FFF, 40'hFFFC000000);
        run_op("zero_mplr", 26'd12345, 14'd0, 14'd5, 40'd5);

        // Backpressure: hold DONE for 5 clocks while throwing junk at the inputs.
        out_ready = 1'b0;
        start_and_wait(26'd1000, 14'd1000, 14'd17, lat);
        check("bp_latency", 64'(lat), 64'd14);
        check("bp_product", 64'(product), 64'd1000017);
        held = product;
        for (int k = 0; k < 5; k++) begin
            multiplicand = 26'h155AAAA;
            multiplier   = 14'h2AAA;
            addend       = 14'h1111;
            in_valid     = 1'b1;
            step();
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_product_stable", 64'(product), 64'(held));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_release_product", 64'(product), 64'd1000017);

        // Reset in the middle of BUSY.
        multiplicand = 26'h1234;
        multiplier   = 14'h0FF;
        addend       = 14'd1;
        in_valid     = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) step();
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_product", 64'(product), 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        step();
        rst = 1'b0;
        step();
        check("rst_after_out_valid", 64'(out_valid), 64'd0);
        run_op("post_rst", 26'd2, 14'd3, 14'd0, 40'd6);

        // Divider round trip, back-to-back with in_valid held high.
        for (int i = 0; i < 1000; i++) begin
            dvd[i] = M'($urandom);
            dvs[i] = N'($urandom_range(1, (1 << N) - 1));
        end
        out_ready = 1'b1;
        q = dvd[0] / M'(dvs[0]);
        r = N'(dvd[0] % M'(dvs[0]));
        multiplicand = q;
        multiplier   = dvs[0];
        addend       = r;
        in_valid     = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            wait_cnt = 0;
            while (!in_ready && wait_cnt < 10) begin
                step();
                wait_cnt++;
            end
            step();
            lat = 0;
            while (!out_valid && lat < 100) begin
                step();
                lat++;
            end
            check("roundtrip", 64'(product), 64'(dvd[i]));
            if (i < 999) begin
                q = dvd[i+1] / M'(dvs[i+1]);
                r = N'(dvd[i+1] % M'(dvs[i+1]));
                multiplicand = q;
                multiplier   = dvs[i+1];
                addend       = r;
            end else begin
                in_valid = 1'b0;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
